// File: rtl/pvt_pkg.sv
// Shared definitions for the UART command receiver: command type codes,
// byte-level and command-level state encodings, the decoded command record
// and the default write-header timeout.
package pvt_pkg;

  localparam int TIMEOUT_CYCLES_DFLT = 64;

  localparam logic [2:0] CMD_WR_HDR = 3'd0;
  localparam logic [2:0] CMD_RD     = 3'd2;

  typedef enum logic [1:0] {
    BY_IDLE,
    BY_DATA,
    BY_STOP,
    BY_BREAK
  } byte_state_e;

  typedef enum logic {
    CM_EXP_HDR,
    CM_EXP_DATA
  } cmd_state_e;

  typedef struct packed {
    logic [2:0] typ;
    logic [4:0] addr;
    logic [7:0] wdata;
  } cmd_t;

endpackage

// File: rtl/pvt_uart_cmd_rx_if.sv
// Decoded-command handshake between the UART command receiver (master)
// and the downstream sensor wrapper (slave).
interface pvt_uart_cmd_rx_if;

  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_type;
  logic [4:0] cmd_addr;
  logic [7:0] cmd_wdata;

  modport master (
    output cmd_valid,
    output cmd_type,
    output cmd_addr,
    output cmd_wdata,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_type,
    input  cmd_addr,
    input  cmd_wdata,
    output cmd_ready
  );

endinterface

// File: rtl/pvt_uart_rx_byte.sv
// Byte receiver: one bit per clock, start bit low, 8 data bits MSB first,
// stop bit high. A good frame pulses o_byte_valid the cycle after the stop
// sample; a low stop bit pulses o_frame_err and parks in BREAK until the
// line is seen high again.
module pvt_uart_rx_byte
  import pvt_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rx,
  output logic       o_byte_valid,
  output logic [7:0] o_byte_data,
  output logic       o_frame_err,
  output logic       o_idle
);

  byte_state_e r_state;
  logic [2:0]  r_cnt;
  logic [7:0]  r_shift;
  logic        r_valid;
  logic        r_ferr;

  // Byte framing FSM: start detect, MSB-first shift, stop check, break hold
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= BY_IDLE;
      r_cnt   <= 3'd0;
      r_shift <= 8'd0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      case (r_state)
        BY_IDLE: begin
          if (!i_rx) begin
            r_state <= BY_DATA;
            r_cnt   <= 3'd7;
          end
        end
        BY_DATA: begin
          r_shift <= {r_shift[6:0], i_rx};
          if (r_cnt == 3'd0) r_state <= BY_STOP;
          else               r_cnt   <= r_cnt - 3'd1;
        end
        BY_STOP: begin
          if (i_rx) begin
            r_valid <= 1'b1;
            r_state <= BY_IDLE;
          end else begin
            r_ferr  <= 1'b1;
            r_state <= BY_BREAK;
          end
        end
        BY_BREAK: begin
          if (i_rx) r_state <= BY_IDLE;
        end
        default: r_state <= BY_IDLE;
      endcase
    end
  end

  // The shift register is frozen outside DATA, so it doubles as the byte output
  assign o_byte_valid = r_valid;
  assign o_byte_data  = r_shift;
  assign o_frame_err  = r_ferr;
  assign o_idle       = (r_state == BY_IDLE);

endmodule

// File: rtl/pvt_uart_cmd_rx.sv
// UART command receiver: turns one- or two-byte host commands into a
// valid/ready command stream. Header byte is {type[7:5], addr[4:0]};
// type 0 is a write header followed by one data byte, type 2 is a read.
// Optional build macro PVT_CMD_TIMEOUT_EN bounds the idle gap between a
// write header and its data byte to TIMEOUT_CYCLES.
module pvt_uart_cmd_rx
  import pvt_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DFLT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  pvt_uart_cmd_rx_if.master cmd,
  output logic              frame_err,
  output logic              cmd_err,
  output logic              busy
);

  logic       w_byte_valid;
  logic       w_byte_ferr;
  logic       w_byte_idle;
  logic [7:0] w_byte_data;

  cmd_state_e r_cmd_st;
  logic [4:0] r_addr_lat;
  cmd_t       r_cmd;
  logic       r_valid;
  logic       r_ferr;
  logic       r_cerr;

  logic       w_done;
  logic       w_ill;
  logic       w_to;
  logic       w_accept;
  cmd_t       w_new;

  pvt_uart_rx_byte u_byte (
    .clk          (clk),
    .rst          (rst),
    .i_rx         (rx),
    .o_byte_valid (w_byte_valid),
    .o_byte_data  (w_byte_data),
    .o_frame_err  (w_byte_ferr),
    .o_idle       (w_byte_idle)
  );

  // Decode a received byte into a completed command or an illegal header
  always_comb begin
    w_done = 1'b0;
    w_ill  = 1'b0;
    w_new  = '0;
    if (w_byte_valid) begin
      if (r_cmd_st == CM_EXP_DATA) begin
        w_done      = 1'b1;
        w_new.typ   = CMD_WR_HDR;
        w_new.addr  = r_addr_lat;
        w_new.wdata = w_byte_data;
      end else if (w_byte_data[7:5] == CMD_RD) begin
        w_done     = 1'b1;
        w_new.typ  = CMD_RD;
        w_new.addr = w_byte_data[4:0];
      end else if (w_byte_data[7:5] != CMD_WR_HDR) begin
        w_ill = 1'b1;
      end
    end
  end

  // A finished command may load if the slot is empty or being drained now
  assign w_accept = !r_valid || cmd.cmd_ready;

`ifdef PVT_CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] r_to_cnt;
  logic          w_quiet;

  // A quiet cycle: waiting for write data, line idle, no start bit, no byte event
  assign w_quiet = (r_cmd_st == CM_EXP_DATA) && w_byte_idle && rx &&
                   !w_byte_valid && !w_byte_ferr;
  assign w_to    = w_quiet && (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Count consecutive quiet cycles; any activity or expiry restarts the count
  always_ff @(posedge clk) begin
    if (rst)                  r_to_cnt <= '0;
    else if (!w_quiet || w_to) r_to_cnt <= '0;
    else                      r_to_cnt <= r_to_cnt + 1'b1;
  end
`else
  logic w_unused_to;

  assign w_to        = 1'b0;
  assign w_unused_to = (TIMEOUT_CYCLES != 0);
`endif

  // Command FSM plus output holding register with overrun detection
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmd_st   <= CM_EXP_HDR;
      r_addr_lat <= 5'd0;
      r_cmd      <= '0;
      r_valid    <= 1'b0;
      r_ferr     <= 1'b0;
      r_cerr     <= 1'b0;
    end else begin
      r_ferr <= w_byte_ferr;
      r_cerr <= w_ill || w_to || (w_done && !w_accept);
      if (w_done && w_accept) begin
        r_valid <= 1'b1;
        r_cmd   <= w_new;
      end else if (r_valid && cmd.cmd_ready) begin
        r_valid <= 1'b0;
      end
      case (r_cmd_st)
        CM_EXP_HDR: begin
          if (w_byte_valid && (w_byte_data[7:5] == CMD_WR_HDR)) begin
            r_cmd_st   <= CM_EXP_DATA;
            r_addr_lat <= w_byte_data[4:0];
          end
        end
        CM_EXP_DATA: begin
          if (w_byte_valid || w_byte_ferr || w_to) r_cmd_st <= CM_EXP_HDR;
        end
        default: r_cmd_st <= CM_EXP_HDR;
      endcase
    end
  end

  assign cmd.cmd_valid = r_valid;
  assign cmd.cmd_type  = r_cmd.typ;
  assign cmd.cmd_addr  = r_cmd.addr;
  assign cmd.cmd_wdata = r_cmd.wdata;
  assign frame_err     = r_ferr;
  assign cmd_err       = r_cerr;
  assign busy          = !w_byte_idle || (r_cmd_st == CM_EXP_DATA);

endmodule

// File: doc/pvt_uart_cmd_rx.md
PVT_UART_CMD_RX -- requirements
Module: pvt_uart_cmd_rx

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64: idle cycles allowed between a write header and its data byte.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 rx  in  1  serial line from host; idles high.
REQ-005 cmd_valid  out  1  decoded command available.
REQ-006 cmd_ready  in  1  downstream sensor wrapper accepts the command.
REQ-007 cmd_type  out  3  command type: 0 write, 2 read.
REQ-008 cmd_addr  out  5  sensor register address.
REQ-009 cmd_wdata  out  8  write data; 0 for reads.
REQ-010 frame_err  out  1  one-cycle pulse when a stop bit is sampled low.
REQ-011 cmd_err  out  1  one-cycle pulse on an illegal type, an overrun or a timeout.
REQ-012 busy  out  1  high while a byte or a two-byte command is in progress.

Function
REQ-013 Serial format: one bit per clk; start bit low, 8 data bits MSB first, stop bit high.
REQ-014 Byte timing: if the start bit is sampled in IDLE at cycle S, data bits are sampled at S+1..S+8 and the stop bit at S+9.
REQ-015 Byte FSM states: IDLE, DATA (3-bit counter, counts 7 down to 0), STOP, BREAK.
REQ-016 Stop bit low: pulse frame_err at S+10, discard the byte, move to BREAK; leave BREAK only after rx is sampled high.
REQ-017 Header byte: {type[7:5], addr[4:0]}.
REQ-018 Command FSM states: EXP_HDR, EXP_DATA.
REQ-019 Header type 0: latch addr, go to EXP_DATA; the next good byte becomes wdata, field decode ignored.
REQ-020 Header type 2: read command with wdata=0, complete immediately.
REQ-021 Header types 1, 3-7 in EXP_HDR: pulse cmd_err, drop the byte, stay in EXP_HDR.
REQ-022 A framing error while in EXP_DATA: abort to EXP_HDR and discard the latched header.
REQ-023 Completion latency: cmd_valid rises at S+10 of the final byte of the command.
REQ-024 Handshake: cmd_valid/type/addr/wdata stay stable until the cycle cmd_valid and cmd_ready are both high; cmd_valid falls on the next cycle unless a new command loads.
REQ-025 Overrun: a command completing while cmd_valid=1 and cmd_ready=0 is dropped, cmd_err pulses, and the held command is unchanged.
REQ-026 Simultaneous accept and completion in the same cycle: load the new command, keep cmd_valid=1, no cmd_err.
REQ-027 busy = (byte FSM not IDLE) or (command FSM in EXP_DATA).

Reset
REQ-028 Reset values: all outputs 0, byte FSM IDLE, command FSM EXP_HDR, counters 0.
REQ-029 Reset mid-frame or mid-command discards all partial data; reception resumes on the first low rx after reset deasserts.

Configuration
REQ-030 Macro PVT_CMD_TIMEOUT_EN defined: in EXP_DATA with the byte FSM in IDLE for TIMEOUT_CYCLES consecutive cycles, pulse cmd_err and return to EXP_HDR; the counter clears on any start bit.
REQ-031 PVT_CMD_TIMEOUT_EN undefined: no timeout counter; EXP_DATA waits indefinitely.

Structure
REQ-032 Package pvt_pkg holds the command type constants (CMD_WR_HDR=3'd0, CMD_RD=3'd2), the byte-FSM and command-FSM state enums, and the TIMEOUT_CYCLES default.
REQ-033 Sub-module pvt_uart_rx_byte implements the byte FSM and outputs byte_valid, byte_data and frame_err; the top holds the command FSM, output register and timeout.

Verification
REQ-034 Send 0x02 then 0xA5 with cmd_ready=1 -> one cmd_valid pulse with type 0, addr 0x02, wdata 0xA5, no errors.
REQ-035 Send 0x45 (type 2, addr 5) -> cmd_valid at S+10 with type 2, addr 5, wdata 0x00.
REQ-036 Send 0x33 (type 1) -> cmd_err pulse, no cmd_valid; a following 0x41 decodes normally as read, addr 1.
REQ-037 Send header 0x00 with the stop bit forced low, hold rx low 5 cycles, then send 0x41 -> frame_err pulse, FSM waits in BREAK, then read addr 1 decodes.
REQ-038 Hold cmd_ready=0, send 0x41 then 0x42 -> second read dropped with cmd_err; held command stays addr 1; accept in the completion cycle of the second read -> addr 2 loaded, no cmd_err.
REQ-039 With PVT_CMD_TIMEOUT_EN and TIMEOUT_CYCLES=64, send 0x03 then idle 64 cycles -> cmd_err pulse; a later 0x41 decodes as read, not as write data.
